// File: rtl/uart_pkg.sv
// Shared UART constants, transmitter state encoding and counter sizing helper.
// Pure definitions: no latency or flow control of its own.
package uart_pkg;

   localparam int PARITY_NONE = 0;
   localparam int PARITY_ODD  = 1;
   localparam int PARITY_EVEN = 2;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PAR,
      STOP
   } tx_state_t;

   // A divider of 1 or 2 still needs a one-bit counter.
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/uart_tx_frame_if.sv
// Producer-to-transmitter word handshake, valid/ready.
// A word moves on any cycle with tx_valid && tx_ready; the producer holds it otherwise.
interface uart_tx_frame_if #(
   parameter int DATA_BITS = 8
);
   logic                 tx_valid;
   logic [DATA_BITS-1:0] tx_din;
   logic                 tx_ready;

   modport master (output tx_valid, output tx_din, input tx_ready);
   modport slave  (input tx_valid, input tx_din, output tx_ready);

endinterface

// File: rtl/uart_tx_frame_baud_gen.sv
// Bit-period timer: bit_end pulses combinationally on the last cycle of each bit period.
// No backpressure; clear restarts the period from zero on the following cycle.
module uart_baud_gen
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 10416
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic bit_end
);
   localparam int            CW   = cnt_width(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst || clear || bit_end) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   assign bit_end = (cnt == LAST);

endmodule

// File: rtl/uart_tx_frame.sv
// UART frame transmitter with one-entry holding register; line goes low 2 cycles after acceptance.
// tx_ready drops for the cycle after acceptance and returns one cycle after the shifter takes the word.
module uart_tx_frame
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 10416,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic               clk,
   input  logic               rst,
   uart_tx_frame_if.slave     tx,
   output logic               tx_serial,
   output logic               tx_active,
   output logic               tx_done
);
   localparam int IW = 4;

   if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535 || DATA_BITS < 5 || DATA_BITS > 9 ||
       PARITY < 0 || PARITY > 2 || (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_bad_param
      $error("uart_tx_frame: parameter out of range");
   end

   tx_state_t            state, state_nxt;
   logic [DATA_BITS-1:0] hold_q, shift_q;
   logic                 hold_full, rdy_q, par_q, done_q;
   logic [IW-1:0]        idx_q;
   logic                 bit_end, load, accept, baud_clear;

   assign tx.tx_ready = rdy_q & ~rst;
   assign accept      = tx.tx_valid & tx.tx_ready;
   assign baud_clear  = (state == IDLE) || (state_nxt != state);

   uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
      .clk     (clk),
      .rst     (rst),
      .clear   (baud_clear),
      .bit_end (bit_end)
   );

   // load marks the edge on which the shifter takes the holding register.
   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      case (state)
         IDLE: begin
            if (hold_full) begin
               state_nxt = START;
               load      = 1'b1;
            end
         end
         START: begin
            if (bit_end) state_nxt = DATA;
         end
         DATA: begin
            if (bit_end && idx_q == IW'(DATA_BITS - 1)) begin
               state_nxt = (PARITY != PARITY_NONE) ? PAR : STOP;
            end
         end
         PAR: begin
            if (bit_end) state_nxt = STOP;
         end
         STOP: begin
            if (bit_end && idx_q == IW'(STOP_BITS - 1)) begin
               if (hold_full) begin
                  state_nxt = START;
                  load      = 1'b1;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      tx_serial = 1'b1;
      case (state)
         START:   tx_serial = 1'b0;
         DATA:    tx_serial = shift_q[0];
         PAR:     tx_serial = par_q;
         default: tx_serial = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         hold_q    <= '0;
         hold_full <= 1'b0;
         rdy_q     <= 1'b1;
         shift_q   <= '0;
         par_q     <= 1'b0;
         idx_q     <= '0;
         done_q    <= 1'b0;
      end else begin
         state  <= state_nxt;
         done_q <= (state == STOP) && (state_nxt != STOP);

         // rdy_q lags hold_full by a cycle so ready reappears the cycle after the shifter load.
         if (accept) begin
            hold_q    <= tx.tx_din;
            hold_full <= 1'b1;
            rdy_q     <= 1'b0;
         end else begin
            rdy_q <= ~hold_full;
            if (load) hold_full <= 1'b0;
         end

         if (load) begin
            shift_q <= hold_q;
            par_q   <= (PARITY == PARITY_EVEN) ? ^hold_q : ~^hold_q;
         end else if (state == DATA && bit_end) begin
            shift_q <= shift_q >> 1;
         end

         if (state_nxt != state) begin
            idx_q <= '0;
         end else if (bit_end) begin
            idx_q <= idx_q + 1'b1;
         end
      end
   end

   assign tx_active = (state != IDLE);
   assign tx_done   = done_q;

endmodule
